// File: rtl/ansi_input_decoder.sv
// ansi_input_decoder: turns the raw stdin byte stream into one-cycle key events.
// Define ANSI_DEC_CPR_EN to also decode Cursor Position Reports (ESC [ row ; col R).
module ansi_input_decoder #(
    parameter int ESC_TIMEOUT = 4,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       cpr_valid,
    output logic [7:0] cpr_row,
    output logic [7:0] cpr_col,
    output logic       err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ESC  = 2'd1,
        ST_CSI1 = 2'd2,
        ST_CSI2 = 2'd3
    } state_t;

    localparam logic [7:0]       B_ESC    = 8'h1B;
    localparam logic [7:0]       B_LBR    = 8'h5B;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ESC_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    state_t           state_r;
    state_t           state_nx_s;
    logic [TMR_W-1:0] tmr_r;
    logic [TMR_W-1:0] tmr_nx_s;
    logic             accept_s;
    logic             timeout_s;
    logic             arrow_s;
    logic             seen_s;
    logic             key_valid_s;
    logic             err_s;
    logic [7:0]       key_code_s;

    // 00 and FF are filler bytes: they count as silence, not as input
    assign accept_s  = in_valid && (in_byte != 8'h00) && (in_byte != 8'hFF);
    assign timeout_s = !accept_s && (tmr_r >= TMR_LAST);
    assign arrow_s   = (in_byte >= 8'h41) && (in_byte <= 8'h44);

`ifdef ANSI_DEC_CPR_EN
    logic [7:0] row_acc_r;
    logic [7:0] row_acc_nx_s;
    logic [7:0] col_acc_r;
    logic [7:0] col_acc_nx_s;
    logic       digit_seen_r;
    logic       digit_seen_nx_s;
    logic       is_digit_s;
    logic       is_semi_s;
    logic       is_r_s;
    logic       cpr_valid_s;

    function automatic logic [7:0] sat_mac(input logic [7:0] acc, input logic [3:0] d);
        logic [11:0] sum;
        sum = ({4'd0, acc} * 12'd10) + {8'd0, d};
        return (sum > 12'd255) ? 8'hFF : sum[7:0];
    endfunction

    assign is_digit_s = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign is_semi_s  = (in_byte == 8'h3B);
    assign is_r_s     = (in_byte == 8'h52);
    assign seen_s     = digit_seen_r;

    // accumulator next values: cleared on CSI entry, one decimal digit per accepted byte
    always_comb begin
        row_acc_nx_s    = row_acc_r;
        col_acc_nx_s    = col_acc_r;
        digit_seen_nx_s = digit_seen_r;
        if (accept_s && (state_r == ST_ESC) && (in_byte == B_LBR)) begin
            row_acc_nx_s    = 8'd0;
            col_acc_nx_s    = 8'd0;
            digit_seen_nx_s = 1'b0;
        end else if (accept_s && (state_r == ST_CSI1) && is_digit_s) begin
            row_acc_nx_s    = sat_mac(row_acc_r, in_byte[3:0]);
            digit_seen_nx_s = 1'b1;
        end else if (accept_s && (state_r == ST_CSI2) && is_digit_s) begin
            col_acc_nx_s = sat_mac(col_acc_r, in_byte[3:0]);
        end else begin
            digit_seen_nx_s = digit_seen_r;
        end
    end

    // accumulator and report registers
    always_ff @(posedge clk) begin
        if (rst) begin
            row_acc_r    <= 8'd0;
            col_acc_r    <= 8'd0;
            digit_seen_r <= 1'b0;
            cpr_valid    <= 1'b0;
            cpr_row      <= 8'd0;
            cpr_col      <= 8'd0;
        end else begin
            row_acc_r    <= row_acc_nx_s;
            col_acc_r    <= col_acc_nx_s;
            digit_seen_r <= digit_seen_nx_s;
            cpr_valid    <= cpr_valid_s;
            if (cpr_valid_s) begin
                cpr_row <= row_acc_r;
                cpr_col <= col_acc_r;
            end
        end
    end
`else
    assign seen_s    = 1'b0;
    assign cpr_valid = 1'b0;
    assign cpr_row   = 8'd0;
    assign cpr_col   = 8'd0;
`endif

    // next state and silence timer
    always_comb begin
        state_nx_s = state_r;
        if (accept_s || (state_r == ST_IDLE) || timeout_s) begin
            tmr_nx_s = '0;
        end else begin
            tmr_nx_s = tmr_r + TMR_ONE;
        end
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (in_byte == B_ESC)) state_nx_s = ST_ESC;
                else                                state_nx_s = ST_IDLE;
            end
            ST_ESC: begin
                if (accept_s) begin
                    if (in_byte == B_LBR)      state_nx_s = ST_CSI1;
                    else if (in_byte == B_ESC) state_nx_s = ST_ESC;
                    else                       state_nx_s = ST_IDLE;
                end else if (timeout_s) state_nx_s = ST_IDLE;
                else                    state_nx_s = ST_ESC;
            end
            ST_CSI1: begin
                if (accept_s) begin
`ifdef ANSI_DEC_CPR_EN
                    if (is_digit_s)     state_nx_s = ST_CSI1;
                    else if (is_semi_s) state_nx_s = ST_CSI2;
                    else                state_nx_s = ST_IDLE;
`else
                    state_nx_s = ST_IDLE;
`endif
                end else if (timeout_s) state_nx_s = ST_IDLE;
                else                    state_nx_s = ST_CSI1;
            end
            ST_CSI2: begin
`ifdef ANSI_DEC_CPR_EN
                if (accept_s && is_digit_s)       state_nx_s = ST_CSI2;
                else if (accept_s || timeout_s)   state_nx_s = ST_IDLE;
                else                              state_nx_s = ST_CSI2;
`else
                state_nx_s = ST_IDLE;
`endif
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // pulse outputs; key_code holds its last value between events
    always_comb begin
        key_valid_s = 1'b0;
        key_code_s  = key_code;
        err_s       = 1'b0;
`ifdef ANSI_DEC_CPR_EN
        cpr_valid_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (in_byte != B_ESC)) begin
                    key_valid_s = 1'b1;
                    key_code_s  = in_byte;
                end else begin
                    key_valid_s = 1'b0;
                end
            end
            ST_ESC: begin
                if (accept_s) begin
                    if (in_byte == B_LBR) begin
                        key_valid_s = 1'b0;
                    end else begin
                        key_valid_s = 1'b1;
                        key_code_s  = B_ESC;
                        err_s       = (in_byte != B_ESC);
                    end
                end else if (timeout_s) begin
                    key_valid_s = 1'b1;
                    key_code_s  = B_ESC;
                end else begin
                    key_valid_s = 1'b0;
                end
            end
            ST_CSI1: begin
                if (accept_s) begin
                    if (arrow_s && !seen_s) begin
                        key_valid_s = 1'b1;
                        key_code_s  = 8'h80 + (in_byte - 8'h41);
`ifdef ANSI_DEC_CPR_EN
                    end else if (is_digit_s || is_semi_s) begin
                        err_s = 1'b0;
`endif
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    err_s = timeout_s;
                end
            end
            ST_CSI2: begin
`ifdef ANSI_DEC_CPR_EN
                if (accept_s) begin
                    if (is_digit_s)  err_s = 1'b0;
                    else if (is_r_s) cpr_valid_s = 1'b1;
                    else             err_s = 1'b1;
                end else begin
                    err_s = timeout_s;
                end
`else
                err_s = accept_s || timeout_s;
`endif
            end
            default: err_s = 1'b0;
        endcase
    end

    // state, timer and key/err output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            tmr_r     <= '0;
            key_valid <= 1'b0;
            key_code  <= 8'h00;
            err       <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            tmr_r     <= tmr_nx_s;
            key_valid <= key_valid_s;
            key_code  <= key_code_s;
            err       <= err_s;
        end
    end
endmodule
